register_file_16x16: RTL and testbench
======================================

# register_file_16x16

Sixteen-entry, 16-bit general-purpose register file for the processor datapath, with two combinational read ports and one synchronous write port. A 4-to-16 one-hot decoder selects the read rows, and each storage bit is a flop-based cell. A same-cycle write to a register being read is bypassed, so the read port returns the new data. The block sits between instruction decode, which supplies register IDs, and the ALU and writeback stage, which consume and supply data.

## Interface
- No parameters. Geometry is fixed at 16 registers x 16 bits, with 4-bit register IDs.
- clk  input  1  system clock; all storage updates on the rising edge
- rst  input  1  asynchronous, active-low reset; clears every register
- srcReg_1  input  4  register ID for read port 1
- srcReg_2  input  4  register ID for read port 2
- dstReg  input  4  register ID for the write port
- writeReg  input  1  write enable; 1 = write dstData into dstReg on the next rising clk
- dstData  input  16  write data
- srcData_1  output  16  contents of srcReg_1, with bypass applied
- srcData_2  output  16  contents of srcReg_2, with bypass applied

## Operation
- Storage: 16 x 16 flop bits, registers R0–R15. All registers are writable; R0 is not hardwired to zero.
- Read decode
  - Each read ID is decoded to a 16-bit one-hot wordline: wordline = 16'h0001 << ID. For example, ID 5 gives 16'h0020 and ID 15 gives 16'h8000.
  - Exactly one bit is set for every ID value.
  - srcData_n is the OR-reduction of (wordline bit AND row data), i.e. a pure mux.
  - No tri-state or high-Z outputs.
- Write decode
  - The one-hot write row is (16'h0001 << dstReg) when writeReg = 1, and 16'h0000 when writeReg = 0.
  - Only the selected row's bits load dstData.
- Bypass: if writeReg = 1 and srcReg_n == dstReg, srcData_n = dstData combinationally. Otherwise srcData_n is the stored value.
  - Both ports bypass independently.
  - Both ports may read the same register, and both return identical data.
- Bit cell: a flop plus write-enable mux; it holds its value when not written.
  - Each of the two read taps outputs the cell's effective value: D if being written this cycle, otherwise the stored Q.
- Reset
  - While rst = 0, all 256 bits are held at 0 and writes are ignored.
  - While rst = 0, srcData_1 and srcData_2 read 16'h0000; the bypass is suppressed.
  - Reset takes effect immediately, without waiting for clk.
- Unknown or X IDs need no defined behaviour.

## Timing
- Read latency: 0 cycles. srcData follows srcReg_n, the stored contents, and the bypass path combinationally within the same cycle.
- Write latency: the data is stored at the first rising clk with writeReg = 1 and rst = 1. It is visible in storage from that edge onward, and via bypass before that edge.
- Same register written on consecutive cycles: each edge stores the then-current dstData, so the last write wins.
- writeReg = 0: no register changes on the edge, whatever dstReg and dstData are.
- Reset deassertion (rst 0 -> 1) is synchronized by the integrator. The first write edge after deassertion behaves normally.
- Reset asserted mid-operation: all contents clear asynchronously, and any write on a coincident edge is lost.

## Test plan
- Reset: drive rst = 0, then release. Read all 16 IDs on both ports -> every srcData = 16'h0000.
- Decoder sweep
  - Apply srcReg_1 = 0..15 -> internal read wordline = 16'h0001 << ID, exactly one bit set.
  - Apply dstReg sweeps with writeReg = 0 -> write wordline = 16'h0000.
- Write then read: write R3 = 16'hA5A5 and R12 = 16'h1234 on successive edges, then set writeReg = 0.
  - srcReg_1 = 3 -> 16'hA5A5; srcReg_2 = 12 -> 16'h1234.
  - srcReg_1 = srcReg_2 = 3 -> both 16'hA5A5.
- Bypass: R7 holds 16'h0F0F. Set writeReg = 1, dstReg = 7, dstData = 16'hBEEF, srcReg_1 = 7, srcReg_2 = 6.
  - Before the edge: srcData_1 = 16'hBEEF and srcData_2 = R6 contents.
  - After the edge with writeReg = 0: srcData_1 = 16'hBEEF.
- Write-disable hold: writeReg = 0, dstReg = 7, dstData = 16'hFFFF for 5 edges -> R7 still reads 16'hBEEF.
- Random regression: 200 cycles of random IDs, data, and writeReg, checked against a 16-entry reference array with the bypass rule. Assert rst = 0 mid-sequence -> all reads 0 immediately, and the reference array is cleared.

Source files
------------

// File: rtl/register_file_16x16.sv
// register_file_16x16: 16 x 16-bit general-purpose register file.
// Two combinational read ports, one synchronous write port, with a same-cycle
// write-to-read bypass. Asynchronous active-low reset clears all storage and
// forces both read ports to zero.
module register_file_16x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  srcReg_1,
  input  logic [3:0]  srcReg_2,
  input  logic [3:0]  dstReg,
  input  logic        writeReg,
  input  logic [15:0] dstData,
  output logic [15:0] srcData_1,
  output logic [15:0] srcData_2
);

  logic [15:0] regFile [16];
  logic [15:0] rdWordline1;
  logic [15:0] rdWordline2;
  logic [15:0] wrWordline;
  logic [15:0] rdMux1;
  logic [15:0] rdMux2;

  // Read and write decoders: one-hot row selects; write row is empty when disabled.
  always_comb begin
    rdWordline1 = 16'h0001 << srcReg_1;
    rdWordline2 = 16'h0001 << srcReg_2;
    wrWordline  = writeReg ? (16'h0001 << dstReg) : 16'h0000;
  end

  // Storage rows: each row loads dstData only when its write wordline is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 16; r++) begin
        regFile[r] <= 16'h0000;
      end
    end else begin
      for (int r = 0; r < 16; r++) begin
        if (wrWordline[r]) begin
          regFile[r] <= dstData;
        end
      end
    end
  end

  // Read muxes: AND-OR over rows of each cell's effective value (the incoming
  // data for the row being written, otherwise the stored value). This is what
  // gives the bypass without a separate compare path.
  always_comb begin
    rdMux1 = 16'h0000;
    rdMux2 = 16'h0000;
    for (int r = 0; r < 16; r++) begin
      rdMux1 = rdMux1 | ({16{rdWordline1[r]}} & (wrWordline[r] ? dstData : regFile[r]));
      rdMux2 = rdMux2 | ({16{rdWordline2[r]}} & (wrWordline[r] ? dstData : regFile[r]));
    end
  end

  // Output gating: reads are forced to zero while reset is held, which also
  // suppresses the bypass during reset.
  always_comb begin
    srcData_1 = rst ? rdMux1 : 16'h0000;
    srcData_2 = rst ? rdMux2 : 16'h0000;
  end

endmodule

// File: tb/tb_register_file_16x16.sv
// tb_register_file_16x16: directed and random checks of register_file_16x16
// against a 16-entry reference array with the bypass rule.
module tb_register_file_16x16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  srcReg_1;
  logic [3:0]  srcReg_2;
  logic [3:0]  dstReg;
  logic        writeReg;
  logic [15:0] dstData;
  logic [15:0] srcData_1;
  logic [15:0] srcData_2;

  int total = 0;
  int bad   = 0;
  logic [15:0] refRegs [16];
  logic [15:0] exp_q [$];

  register_file_16x16 dut (
    .clk(clk), .rst(rst),
    .srcReg_1(srcReg_1), .srcReg_2(srcReg_2),
    .dstReg(dstReg), .writeReg(writeReg), .dstData(dstData),
    .srcData_1(srcData_1), .srcData_2(srcData_2)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] modelRead(input logic [3:0] id);
    if (!rst) return 16'h0000;
    if (writeReg && (id == dstReg)) return dstData;
    return refRegs[id];
  endfunction

  // Advance one rising edge, mirroring the write into the reference array,
  // then step just past the edge so inputs change away from it.
  task automatic tick();
    @(posedge clk);
    if (writeReg && rst) refRegs[dstReg] = dstData;
    #1;
  endtask

  task automatic doWrite(input logic [3:0] id, input logic [15:0] data);
    writeReg = 1'b1;
    dstReg   = id;
    dstData  = data;
    tick();
    writeReg = 1'b0;
  endtask

  task automatic readBoth(input logic [3:0] id1, input logic [3:0] id2);
    srcReg_1 = id1;
    srcReg_2 = id2;
    #1;
  endtask

  initial begin
    logic [15:0] oneHot;
    rst = 1'b0; srcReg_1 = 4'd0; srcReg_2 = 4'd0; dstReg = 4'd2;
    writeReg = 1'b1; dstData = 16'hFFFF;
    for (int i = 0; i < 16; i++) refRegs[i] = 16'h0000;

    // Reset: write attempted during reset must be ignored, reads are zero.
    tick();
    tick();
    readBoth(4'd2, 4'd2);
    checkVal("rst_rd1_bypass_off", srcData_1, 16'h0000);
    checkVal("rst_rd2_bypass_off", srcData_2, 16'h0000);
    writeReg = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      readBoth(i[3:0], 4'(15 - i));
      checkVal("rst_clear_p1", srcData_1, 16'h0000);
      checkVal("rst_clear_p2", srcData_2, 16'h0000);
    end

    // Decoder sweep.
    for (int i = 0; i < 16; i++) begin
      readBoth(i[3:0], 4'd0);
      oneHot = 16'h0001 << i;
      checkVal("rd_wordline", dut.rdWordline1, oneHot);
      dstReg = i[3:0];
      #1;
      checkVal("wr_wordline_off", dut.wrWordline, 16'h0000);
    end

    // Write then read.
    doWrite(4'd3, 16'hA5A5);
    doWrite(4'd12, 16'h1234);
    readBoth(4'd3, 4'd12);
    checkVal("wr_r3", srcData_1, 16'hA5A5);
    checkVal("wr_r12", srcData_2, 16'h1234);
    readBoth(4'd3, 4'd3);
    checkVal("same_p1", srcData_1, 16'hA5A5);
    checkVal("same_p2", srcData_2, 16'hA5A5);

    // Boundary rows and last-write-wins.
    doWrite(4'd0, 16'h8001);
    doWrite(4'd15, 16'h7FFE);
    doWrite(4'd5, 16'h1111);
    doWrite(4'd5, 16'h2222);
    readBoth(4'd0, 4'd15);
    checkVal("r0_writable", srcData_1, 16'h8001);
    checkVal("r15", srcData_2, 16'h7FFE);
    readBoth(4'd5, 4'd3);
    checkVal("last_write_wins", srcData_1, 16'h2222);
    checkVal("r3_kept", srcData_2, 16'hA5A5);

    // Bypass.
    doWrite(4'd7, 16'h0F0F);
    writeReg = 1'b1; dstReg = 4'd7; dstData = 16'hBEEF;
    readBoth(4'd7, 4'd6);
    checkVal("bypass_p1", srcData_1, 16'hBEEF);
    checkVal("bypass_other_p2", srcData_2, 16'h0000);
    readBoth(4'd6, 4'd7);
    checkVal("bypass_p2", srcData_2, 16'hBEEF);
    readBoth(4'd7, 4'd6);
    tick();
    writeReg = 1'b0;
    #1;
    checkVal("bypass_stored", srcData_1, 16'hBEEF);

    // Write-disable hold.
    dstReg = 4'd7; dstData = 16'hFFFF;
    repeat (5) tick();
    readBoth(4'd7, 4'd7);
    checkVal("hold_r7_p1", srcData_1, 16'hBEEF);
    checkVal("hold_r7_p2", srcData_2, 16'hBEEF);

    // Random regression with a mid-sequence asynchronous reset.
    for (int c = 0; c < 200; c++) begin
      srcReg_1 = 4'($urandom_range(0, 15));
      srcReg_2 = 4'($urandom_range(0, 15));
      dstReg   = 4'($urandom_range(0, 15));
      dstData  = 16'($urandom_range(0, 65535));
      writeReg = 1'($urandom_range(0, 1));
      if (c == 100) rst = 1'b0;
      if (c == 103) rst = 1'b1;
      #1;
      if (c == 100) begin
        for (int i = 0; i < 16; i++) refRegs[i] = 16'h0000;
        checkVal("async_rst_p1", srcData_1, 16'h0000);
        checkVal("async_rst_p2", srcData_2, 16'h0000);
      end
      exp_q.push_back(modelRead(srcReg_1));
      exp_q.push_back(modelRead(srcReg_2));
      checkVal("rand_p1", srcData_1, exp_q.pop_front());
      checkVal("rand_p2", srcData_2, exp_q.pop_front());
      tick();
    end

    // Final report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
